// File: rtl/audio_pkg.sv
// Shared constants for the jingle player and the game FSM: pitch and select codes,
// the pitch half-period table and the note entry record.
package audio_pkg;

  localparam int MAX_NOTES = 8;
  localparam int IDX_W     = 3;

  localparam logic [3:0] PITCH_REST = 4'd0;
  localparam logic [3:0] PITCH_C5   = 4'd1;
  localparam logic [3:0] PITCH_CS5  = 4'd2;
  localparam logic [3:0] PITCH_D5   = 4'd3;
  localparam logic [3:0] PITCH_DS5  = 4'd4;
  localparam logic [3:0] PITCH_E5   = 4'd5;
  localparam logic [3:0] PITCH_F5   = 4'd6;
  localparam logic [3:0] PITCH_FS5  = 4'd7;
  localparam logic [3:0] PITCH_G5   = 4'd8;
  localparam logic [3:0] PITCH_GS5  = 4'd9;
  localparam logic [3:0] PITCH_A5   = 4'd10;
  localparam logic [3:0] PITCH_AS5  = 4'd11;
  localparam logic [3:0] PITCH_B5   = 4'd12;
  localparam logic [3:0] PITCH_C6   = 4'd13;
  localparam logic [3:0] PITCH_TERM = 4'hF;

  localparam logic [3:0] SEL_LEVEL_UP  = 4'd2;
  localparam logic [3:0] SEL_WORLD_UP  = 4'd3;
  localparam logic [3:0] SEL_LIFE_LOST = 4'd4;
  localparam logic [3:0] SEL_WIN       = 4'd5;
  localparam logic [3:0] SEL_LOSE      = 4'd6;

  typedef struct packed {
    logic [3:0] pitch;
    logic [7:0] dur;
  } note_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_NOTE,
    ST_GAP
  } seq_state_t;

  // Half-period in 100 MHz clock cycles; 0 for rest and unused codes.
  function automatic logic [16:0] halfPeriod(input logic [3:0] pitch);
    logic [16:0] half;
    case (pitch)
      PITCH_C5:  half = 17'd95557;
      PITCH_CS5: half = 17'd90193;
      PITCH_D5:  half = 17'd85131;
      PITCH_DS5: half = 17'd80354;
      PITCH_E5:  half = 17'd75843;
      PITCH_F5:  half = 17'd71586;
      PITCH_FS5: half = 17'd67568;
      PITCH_G5:  half = 17'd63776;
      PITCH_GS5: half = 17'd60196;
      PITCH_A5:  half = 17'd56818;
      PITCH_AS5: half = 17'd53629;
      PITCH_B5:  half = 17'd50619;
      PITCH_C6:  half = 17'd47778;
      default:   half = 17'd0;
    endcase
    return half;
  endfunction

  function automatic logic isValidSel(input logic [3:0] sel);
    return (sel >= SEL_LEVEL_UP) && (sel <= SEL_LOSE);
  endfunction

  function automatic note_t mkNote(input logic [3:0] pitch, input logic [7:0] dur);
    note_t n;
    n.pitch = pitch;
    n.dur   = dur;
    return n;
  endfunction

endpackage

// File: rtl/jingle_rom.sv
// Combinational jingle table: {select code, note index} -> {pitch, duration units}.
// Unused slots and unknown codes return the terminator.
module jingle_rom
  import audio_pkg::*;
(
  input  logic [3:0]       i_sel,
  input  logic [IDX_W-1:0] i_idx,
  output note_t            o_entry
);

  always_comb begin
    o_entry = mkNote(PITCH_TERM, 8'd0);
    case (i_sel)
      SEL_LEVEL_UP: begin
        case (i_idx)
          3'd0:    o_entry = mkNote(PITCH_C5, 8'd8);
          3'd1:    o_entry = mkNote(PITCH_E5, 8'd8);
          3'd2:    o_entry = mkNote(PITCH_G5, 8'd16);
          default: ;
        endcase
      end
      SEL_WORLD_UP: begin
        case (i_idx)
          3'd0:    o_entry = mkNote(PITCH_C5, 8'd8);
          3'd1:    o_entry = mkNote(PITCH_E5, 8'd8);
          3'd2:    o_entry = mkNote(PITCH_G5, 8'd8);
          3'd3:    o_entry = mkNote(PITCH_C6, 8'd24);
          default: ;
        endcase
      end
      SEL_LIFE_LOST: begin
        case (i_idx)
          3'd0:    o_entry = mkNote(PITCH_G5, 8'd12);
          3'd1:    o_entry = mkNote(PITCH_E5, 8'd12);
          3'd2:    o_entry = mkNote(PITCH_C5, 8'd24);
          default: ;
        endcase
      end
      SEL_WIN: begin
        case (i_idx)
          3'd0:    o_entry = mkNote(PITCH_C5, 8'd8);
          3'd1:    o_entry = mkNote(PITCH_C5, 8'd8);
          3'd2:    o_entry = mkNote(PITCH_G5, 8'd8);
          3'd3:    o_entry = mkNote(PITCH_G5, 8'd8);
          3'd4:    o_entry = mkNote(PITCH_A5, 8'd8);
          3'd5:    o_entry = mkNote(PITCH_A5, 8'd8);
          3'd6:    o_entry = mkNote(PITCH_G5, 8'd32);
          default: ;
        endcase
      end
      SEL_LOSE: begin
        case (i_idx)
          3'd0:    o_entry = mkNote(PITCH_E5, 8'd16);
          3'd1:    o_entry = mkNote(PITCH_DS5, 8'd16);
          3'd2:    o_entry = mkNote(PITCH_D5, 8'd16);
          3'd3:    o_entry = mkNote(PITCH_CS5, 8'd40);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/audio_sequencer.sv
// Jingle player: steps through a note list as square-wave tones separated by one
// silent duration unit, and reports seqEnd back to the game FSM.
module audio_sequencer
  import audio_pkg::*;
#(
  parameter int          TICK_DIV      = 100_000,
  parameter int          DUR_UNIT      = 10,
  parameter logic [16:0] HALF_OVERRIDE = 17'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] audioSelect,
  input  logic       audioEnable,
  input  logic       mute,
  output logic       audioOut,
  output logic       audioSD,
  output logic       seqEnd,
  output logic       busy,
  output logic [2:0] noteIdx
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int UNIT_W = $clog2(DUR_UNIT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(DUR_UNIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(MAX_NOTES - 1);

  seq_state_t       r_state;
  seq_state_t       w_nextState;
  logic [3:0]       r_code;
  logic [3:0]       w_loadCode;
  logic             r_pending;
  logic [3:0]       r_pendCode;
  logic             w_setPend;
  logic             w_advance;
  logic [IDX_W-1:0] r_noteIdx;
  logic [IDX_W-1:0] w_romIdx;
  note_t            w_romEntry;
  note_t            r_entry;

  logic [TICK_W-1:0] r_tickCnt;
  logic [UNIT_W-1:0] r_unitTick;
  logic [7:0]        r_unitCnt;
  logic              w_tickEnd;
  logic              w_unitEnd;
  logic              w_noteEnd;
  logic              w_lastNote;
  logic              w_restart;
  logic              w_trig;
  logic              w_retrig;

  logic [16:0] r_halfCnt;
  logic [16:0] w_halfNext;
  logic [16:0] w_halfPer;
  logic        r_tone;
  logic        w_toneNext;

  logic r_audioOut;
  logic r_audioSD;
  logic r_seqEnd;
  logic r_busy;

  assign w_trig     = audioEnable && isValidSel(audioSelect);
  assign w_retrig   = w_trig && (audioSelect != r_code);
  assign w_tickEnd  = (r_tickCnt == TICK_LAST);
  assign w_unitEnd  = w_tickEnd && (r_unitTick == UNIT_LAST);
  assign w_noteEnd  = w_unitEnd && (r_unitCnt == r_entry.dur - 8'd1);
  assign w_romIdx   = (r_state == ST_GAP) ? r_noteIdx + 3'd1 : 3'd0;
  assign w_lastNote = (r_noteIdx == IDX_LAST) || (w_romEntry.pitch == PITCH_TERM);
  assign w_restart  = (w_nextState != r_state) || (w_nextState == ST_LOAD);

  jingle_rom u_rom (
    .i_sel   (r_code),
    .i_idx   (w_romIdx),
    .o_entry (w_romEntry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nextState;
  end

  // A trigger landing on the final gap edge is parked in r_pending and started from IDLE.
  always_comb begin
    w_nextState = r_state;
    w_loadCode  = r_code;
    w_setPend   = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_nextState = ST_LOAD;
          w_loadCode  = audioSelect;
        end else if (r_pending) begin
          w_nextState = ST_LOAD;
          w_loadCode  = r_pendCode;
        end
      end
      ST_LOAD: begin
        w_nextState = ST_NOTE;
        if (w_retrig) begin
          w_nextState = ST_LOAD;
          w_loadCode  = audioSelect;
        end
      end
      ST_NOTE: begin
        if (w_retrig) begin
          w_nextState = ST_LOAD;
          w_loadCode  = audioSelect;
        end else if (w_noteEnd) begin
          w_nextState = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_unitEnd && w_lastNote) begin
          w_nextState = ST_IDLE;
          w_setPend   = w_trig;
        end else if (w_retrig) begin
          w_nextState = ST_LOAD;
          w_loadCode  = audioSelect;
        end else if (w_unitEnd) begin
          w_nextState = ST_NOTE;
          w_advance   = 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_code     <= 4'd0;
      r_pending  <= 1'b0;
      r_pendCode <= 4'd0;
      r_noteIdx  <= '0;
      r_entry    <= '0;
    end else begin
      r_pending <= w_setPend;
      if (w_setPend) r_pendCode <= audioSelect;
      if (w_nextState == ST_LOAD) r_code <= w_loadCode;
      if (w_nextState == ST_LOAD || w_nextState == ST_IDLE) r_noteIdx <= '0;
      else if (w_advance) r_noteIdx <= r_noteIdx + 3'd1;
      if (w_nextState == ST_NOTE && r_state != ST_NOTE) r_entry <= w_romEntry;
    end
  end

  // Tick prescaler -> ticks within a unit -> units elapsed in the current note or gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tickCnt  <= '0;
      r_unitTick <= '0;
      r_unitCnt  <= '0;
    end else if (w_restart) begin
      r_tickCnt  <= '0;
      r_unitTick <= '0;
      r_unitCnt  <= '0;
    end else if (r_state == ST_NOTE || r_state == ST_GAP) begin
      if (w_tickEnd) begin
        r_tickCnt <= '0;
        if (r_unitTick == UNIT_LAST) begin
          r_unitTick <= '0;
          r_unitCnt  <= r_unitCnt + 8'd1;
        end else begin
          r_unitTick <= r_unitTick + 1'b1;
        end
      end else begin
        r_tickCnt <= r_tickCnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_halfPer  = (HALF_OVERRIDE != 17'd0) ? HALF_OVERRIDE : halfPeriod(r_entry.pitch);
    w_halfNext = '0;
    w_toneNext = 1'b0;
    if (r_state == ST_NOTE && w_nextState == ST_NOTE && r_entry.pitch != PITCH_REST) begin
      if (r_halfCnt == w_halfPer - 17'd1) begin
        w_halfNext = '0;
        w_toneNext = ~r_tone;
      end else begin
        w_halfNext = r_halfCnt + 17'd1;
        w_toneNext = r_tone;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halfCnt  <= '0;
      r_tone     <= 1'b0;
      r_audioOut <= 1'b0;
      r_audioSD  <= 1'b0;
      r_seqEnd   <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_halfCnt  <= w_halfNext;
      r_tone     <= w_toneNext;
      r_audioOut <= w_toneNext && !mute;
      r_audioSD  <= (w_nextState != ST_IDLE) && !mute;
      r_seqEnd   <= (w_nextState == ST_IDLE);
      r_busy     <= (w_nextState != ST_IDLE);
    end
  end

  assign audioOut = r_audioOut;
  assign audioSD  = r_audioSD;
  assign seqEnd   = r_seqEnd;
  assign busy     = r_busy;
  assign noteIdx  = r_noteIdx;

endmodule

// File: tb/tb_audio_sequencer.sv
// Self-checking bench for audio_sequencer with a fast tempo (1 unit = 8 clk) and
// every tone forced to a 3-cycle half-period.
module tb_audio_sequencer;
  import audio_pkg::*;

  localparam int UNIT  = 8;
  localparam int BOUND = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] audioSelect = 4'd0;
  logic       audioEnable = 1'b0;
  logic       mute = 1'b0;
  logic       audioOut;
  logic       audioSD;
  logic       seqEnd;
  logic       busy;
  logic [2:0] noteIdx;

  always #5 clk = ~clk;

  audio_sequencer #(
    .TICK_DIV      (4),
    .DUR_UNIT      (2),
    .HALF_OVERRIDE (17'd3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .audioSelect (audioSelect),
    .audioEnable (audioEnable),
    .mute        (mute),
    .audioOut    (audioOut),
    .audioSD     (audioSD),
    .seqEnd      (seqEnd),
    .busy        (busy),
    .noteIdx     (noteIdx)
  );

  typedef struct {
    logic [3:0] sel;
    logic       muteOn;
    int         sumDur;
    int         notes;
  } vec_t;

  typedef struct {
    int   cycles;
    int   notes;
    logic muteOn;
  } exp_t;

  int   nChecks = 0;
  int   nFails  = 0;
  exp_t sbQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Single-cycle trigger; returns #1 after the edge that sampled it.
  task automatic applyStimulus(input logic [3:0] sel);
    @(negedge clk);
    audioSelect = sel;
    audioEnable = 1'b1;
    @(posedge clk);
    #1;
    audioEnable = 1'b0;
  endtask

  task automatic runToEnd(input logic expMute, output int cycles, output int maxIdx,
                          output int idxErr, output int sdErr, output int outHigh);
    int prevIdx;
    bit done;
    cycles = 0; maxIdx = 0; idxErr = 0; sdErr = 0; outHigh = 0; done = 0;
    prevIdx = int'(noteIdx);
    while (!done) begin
      @(posedge clk);
      #1;
      cycles++;
      if (seqEnd === 1'b1 || cycles > BOUND) begin
        done = 1;
      end else begin
        if (int'(noteIdx) < prevIdx || int'(noteIdx) > prevIdx + 1) idxErr++;
        prevIdx = int'(noteIdx);
        if (int'(noteIdx) > maxIdx) maxIdx = int'(noteIdx);
        if (busy !== 1'b1 || audioSD !== ~expMute) sdErr++;
        if (audioOut === 1'b1) outHigh++;
      end
    end
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (seqEnd !== 1'b1 && cycles <= BOUND) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    exp_t e;
    int   cyc, maxI, idxErr, sdErr, outHigh, n, err, prev, rest;
    int   idx100, seA, seB;
    bit   done;

    vecs[0] = '{SEL_LEVEL_UP,  1'b0, 32, 3};
    vecs[1] = '{SEL_WORLD_UP,  1'b0, 48, 4};
    vecs[2] = '{SEL_LIFE_LOST, 1'b0, 48, 3};
    vecs[3] = '{SEL_WIN,       1'b0, 80, 7};
    vecs[4] = '{SEL_LOSE,      1'b0, 88, 4};
    vecs[5] = '{SEL_LEVEL_UP,  1'b1, 32, 3};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_seqEnd", seqEnd, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_noteIdx", noteIdx, 0);
    checkOutput("reset_audioOut", audioOut, 0);
    checkOutput("reset_audioSD", audioSD, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_seqEnd", seqEnd, 1);

    for (int v = 0; v < 6; v++) begin
      mute = vecs[v].muteOn;
      sbQ.push_back('{1 + (vecs[v].sumDur + vecs[v].notes) * UNIT, vecs[v].notes, vecs[v].muteOn});
      applyStimulus(vecs[v].sel);
      checkOutput($sformatf("vec%0d_seqEnd_drop", v), seqEnd, 0);
      runToEnd(vecs[v].muteOn, cyc, maxI, idxErr, sdErr, outHigh);
      e = sbQ.pop_front();
      checkOutput($sformatf("vec%0d_length", v), cyc, e.cycles);
      checkOutput($sformatf("vec%0d_notes", v), maxI + 1, e.notes);
      checkOutput($sformatf("vec%0d_noteIdx_steps", v), idxErr, 0);
      checkOutput($sformatf("vec%0d_audioSD_busy", v), sdErr, 0);
      checkOutput($sformatf("vec%0d_tone_active", v), outHigh > 0, !e.muteOn);
      checkOutput($sformatf("vec%0d_end_noteIdx", v), noteIdx, 0);
      checkOutput($sformatf("vec%0d_end_audioSD", v), audioSD, 0);
      mute = 1'b0;
      repeat (3) @(posedge clk);
    end

    // lifeLost note 0: 96 cycles of 3-high/3-low tone, then an 8-cycle silent gap
    applyStimulus(SEL_LIFE_LOST);
    err = 0; prev = 0;
    for (int k = 1; k <= 104; k++) begin
      @(posedge clk);
      #1;
      if (k <= 96) begin
        if (audioOut !== ((((k - 1) / 3) % 2) == 1)) err++;
      end else if (audioOut !== 1'b0) begin
        prev++;
      end
    end
    checkOutput("lifelost_tone_period", err, 0);
    checkOutput("lifelost_gap_silent", prev, 0);
    waitIdle(rest);
    checkOutput("lifelost_length", 104 + rest, 409);
    repeat (3) @(posedge clk);

    applyStimulus(SEL_WIN);
    n = 0; err = 0; prev = 0; maxI = 0; done = 0;
    while (!done) begin
      if (n < 50 && n % 2 == 1) begin
        audioSelect = SEL_WIN;
        audioEnable = 1'b1;
      end else begin
        audioEnable = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (seqEnd === 1'b1 || n > BOUND) begin
        done = 1;
      end else begin
        if (int'(noteIdx) < prev) err++;
        prev = int'(noteIdx);
        if (prev > maxI) maxI = prev;
      end
    end
    audioEnable = 1'b0;
    checkOutput("win_repulse_length", n, 697);
    checkOutput("win_repulse_monotonic", err, 0);
    checkOutput("win_repulse_last_idx", maxI, 6);
    repeat (3) @(posedge clk);

    applyStimulus(SEL_WORLD_UP);
    n = 0; done = 0; idx100 = -1;
    while (!done) begin
      if (n == 39) begin
        audioSelect = SEL_LOSE;
        audioEnable = 1'b1;
      end else begin
        audioEnable = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (n == 100) idx100 = int'(noteIdx);
      if (seqEnd === 1'b1 || n > BOUND) done = 1;
    end
    checkOutput("abort_restart_idx", idx100, 0);
    checkOutput("abort_length", n, 40 + 1 + 92 * UNIT);
    repeat (3) @(posedge clk);

    applyStimulus(4'd7);
    checkOutput("invalid7_seqEnd", seqEnd, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("invalid7_busy", busy, 0);
    applyStimulus(4'd0);
    checkOutput("invalid0_seqEnd", seqEnd, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("invalid0_audioSD", audioSD, 0);

    // trigger on the edge that returns to IDLE: one idle cycle, then a full replay
    applyStimulus(SEL_LEVEL_UP);
    n = 0; done = 0; seA = -1; seB = -1;
    while (!done) begin
      if (n == 280) begin
        audioSelect = SEL_LEVEL_UP;
        audioEnable = 1'b1;
      end else begin
        audioEnable = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (n == 281) seA = int'(seqEnd);
      if (n == 282) seB = int'(seqEnd);
      if ((seqEnd === 1'b1 && n != 281) || n > BOUND) done = 1;
    end
    checkOutput("boundary_seqEnd_at_end", seA, 1);
    checkOutput("boundary_seqEnd_drop", seB, 0);
    checkOutput("boundary_replay_length", n, 282 + 281);
    repeat (3) @(posedge clk);

    applyStimulus(SEL_LEVEL_UP);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("midrun_noteIdx", noteIdx, 1);
    checkOutput("midrun_audioOut", audioOut, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_audioOut", audioOut, 0);
    checkOutput("async_reset_seqEnd", seqEnd, 1);
    checkOutput("async_reset_noteIdx", noteIdx, 0);
    checkOutput("async_reset_audioSD", audioSD, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("after_reset_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
